// File: rtl/cpu_defines.sv
// Shared CPU definitions used by the MEM-stage exception arbiter and CP0.
//   - EXCP_TYPE_* codes carried on exception_type to CP0
//   - CP0 register indices (Status, Cause, EPC)
//   - Status / Cause bit positions
//   - excp_state_t: exception FSM states
//   - excp_select(): fixed-priority exception selection
package cpu_defines;

  // Exception type codes understood by CP0.
  localparam logic [31:0] EXCP_TYPE_NONE         = 32'd0;
  localparam logic [31:0] EXCP_TYPE_INTERRUPT    = 32'd1;
  localparam logic [31:0] EXCP_TYPE_SYSCALL      = 32'd8;
  localparam logic [31:0] EXCP_TYPE_INVALID_INST = 32'd10;
  localparam logic [31:0] EXCP_TYPE_OV           = 32'd12;
  localparam logic [31:0] EXCP_TYPE_ERET         = 32'd14;

  // CP0 register indices.
  localparam logic [4:0] CP0_REG_STATUS = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_REG_EPC    = 5'd14;

  // Status bit positions.
  localparam int STATUS_IE    = 0;
  localparam int STATUS_EXL   = 1;
  localparam int STATUS_IM_HI = 15;
  localparam int STATUS_IM_LO = 8;

  // Cause interrupt-pending field.
  localparam int CAUSE_IP_HI = 15;
  localparam int CAUSE_IP_LO = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    BLANK = 1'b1
  } excp_state_t;

  // Priority: interrupt > invalid_inst > syscall > ov > eret.
  function automatic logic [31:0] excp_select(
    input logic int_pend,
    input logic invalid,
    input logic syscall,
    input logic ov,
    input logic eret
  );
    if (int_pend)     return EXCP_TYPE_INTERRUPT;
    else if (invalid) return EXCP_TYPE_INVALID_INST;
    else if (syscall) return EXCP_TYPE_SYSCALL;
    else if (ov)      return EXCP_TYPE_OV;
    else if (eret)    return EXCP_TYPE_ERET;
    else              return EXCP_TYPE_NONE;
  endfunction

endpackage

// File: rtl/excp_ctrl_cp0_fwd.sv
// cp0_fwd: combinational forwarding of a CP0 write issued by the MEM-stage
// instruction onto the CP0 register values, so the exception decision sees
// the state the instruction is about to create.
// Ports:
//   cp0_we_i, cp0_waddr_i, cp0_wdata_i : CP0 write from MEM
//   status_i, cause_i, epc_i           : current CP0 register values
//   status_o, cause_o, epc_o           : effective (forwarded) values
module cp0_fwd
  import cpu_defines::*;
(
  input  logic        cp0_we_i,
  input  logic [4:0]  cp0_waddr_i,
  input  logic [31:0] cp0_wdata_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o
);

  logic wr_status;
  logic wr_cause;
  logic wr_epc;

  assign wr_status = cp0_we_i && (cp0_waddr_i == CP0_REG_STATUS);
  assign wr_cause  = cp0_we_i && (cp0_waddr_i == CP0_REG_CAUSE);
  assign wr_epc    = cp0_we_i && (cp0_waddr_i == CP0_REG_EPC);

  assign status_o = wr_status ? cp0_wdata_i : status_i;
  // Only the software interrupt bits [9:8] of Cause are writable.
  assign cause_o  = wr_cause ? {cause_i[31:10], cp0_wdata_i[9:8], cause_i[7:0]}
                             : cause_i;
  assign epc_o    = wr_epc ? cp0_wdata_i : epc_i;

endmodule

// File: rtl/excp_ctrl.sv
// excp_ctrl: MEM-stage exception arbiter feeding CP0.
// Each cycle it forwards any CP0 write from MEM, evaluates pending interrupts,
// picks one exception by priority and, when it is accepted, drives CP0's
// exception inputs, flushes IF..MEM and redirects fetch to the handler (or to
// EPC for ERET). A blanking FSM then ignores MEM for FLUSH_CYCLES unstalled
// cycles while the flushed pipeline drains.
// Ports:
//   clk, rst (sync, active-high)
//   stall_i                       : pipeline stall, blocks accept, freezes FSM
//   mem_valid_i, mem_pc_i, mem_in_delayslot_i : MEM instruction
//   mem_syscall_i, mem_invalid_i, mem_ov_i, mem_eret_i : MEM exception flags
//   mem_cp0_we_i/_waddr_i/_wdata_i : CP0 write from MEM (forwarded)
//   cp0_status_i, cp0_cause_i, cp0_epc_i : current CP0 values
//   exception_type_o, pc_o, is_in_delayslot_o : to CP0
//   flush_o, new_pc_o             : pipeline flush and redirect target
//   busy_o                        : FSM is blanking
module excp_ctrl
  import cpu_defines::*;
#(
  parameter logic [31:0] HANDLER_ADDR = 32'h8000_0180,
  parameter int          FLUSH_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_delayslot_i,
  input  logic        mem_syscall_i,
  input  logic        mem_invalid_i,
  input  logic        mem_ov_i,
  input  logic        mem_eret_i,
  input  logic        mem_cp0_we_i,
  input  logic [4:0]  mem_cp0_waddr_i,
  input  logic [31:0] mem_cp0_wdata_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  output logic [31:0] exception_type_o,
  output logic [31:0] pc_o,
  output logic        is_in_delayslot_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        busy_o
);

  localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

  excp_state_t state;
  logic [3:0]  cnt;

  logic [31:0] eff_status;
  logic [31:0] eff_cause;
  logic [31:0] eff_epc;
  logic        int_pend;
  logic [31:0] sel_type;
  logic        accept;

  cp0_fwd u_cp0_fwd (
    .cp0_we_i    (mem_cp0_we_i),
    .cp0_waddr_i (mem_cp0_waddr_i),
    .cp0_wdata_i (mem_cp0_wdata_i),
    .status_i    (cp0_status_i),
    .cause_i     (cp0_cause_i),
    .epc_i       (cp0_epc_i),
    .status_o    (eff_status),
    .cause_o     (eff_cause),
    .epc_o       (eff_epc)
  );

  // Fields of the effective Status/Cause the arbiter does not look at.
  logic unused_fwd_bits;
  assign unused_fwd_bits = ^{eff_status[31:16], eff_status[7:2],
                             eff_cause[31:16], eff_cause[7:0]};

  assign int_pend = eff_status[STATUS_IE] & ~eff_status[STATUS_EXL] &
                    (|(eff_cause[CAUSE_IP_HI:CAUSE_IP_LO] &
                       eff_status[STATUS_IM_HI:STATUS_IM_LO]));

  assign sel_type = excp_select(int_pend, mem_invalid_i, mem_syscall_i,
                                mem_ov_i, mem_eret_i);

  // int_pend is recomputed every cycle, so an interrupt seen during a bubble
  // or stall is simply taken on the next cycle that can accept it.
  assign accept = !rst && (state == IDLE) && !stall_i && mem_valid_i &&
                  (sel_type != EXCP_TYPE_NONE);

  // NOTE: every output gets a default first so no path leaves it unassigned;
  // otherwise always_comb would infer a latch.
  always_comb begin
    exception_type_o  = EXCP_TYPE_NONE;
    pc_o              = 32'd0;
    is_in_delayslot_o = 1'b0;
    flush_o           = 1'b0;
    new_pc_o          = 32'd0;
    if (!rst) begin
      pc_o              = mem_pc_i;
      is_in_delayslot_o = mem_in_delayslot_i;
      if (accept) begin
        exception_type_o = sel_type;
        flush_o          = 1'b1;
        new_pc_o         = (sel_type == EXCP_TYPE_ERET) ? eff_epc : HANDLER_ADDR;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else if (!stall_i) begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= BLANK;
            cnt   <= CNT_LOAD;
          end
        end
        BLANK: begin
          if (cnt == 4'd0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  assign busy_o = (state == BLANK);

endmodule

// File: tb/tb_excp_ctrl.sv
// Directed self-checking bench for excp_ctrl (default parameters:
// handler 0x8000_0180, 3 blanking cycles). Inputs change 1 time unit after
// the rising edge; outputs are checked 1 time unit later.
module tb_excp_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        mem_valid_i;
  logic [31:0] mem_pc_i;
  logic        mem_in_delayslot_i;
  logic        mem_syscall_i;
  logic        mem_invalid_i;
  logic        mem_ov_i;
  logic        mem_eret_i;
  logic        mem_cp0_we_i;
  logic [4:0]  mem_cp0_waddr_i;
  logic [31:0] mem_cp0_wdata_i;
  logic [31:0] cp0_status_i;
  logic [31:0] cp0_cause_i;
  logic [31:0] cp0_epc_i;
  logic [31:0] exception_type_o;
  logic [31:0] pc_o;
  logic        is_in_delayslot_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        busy_o;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] HANDLER = 32'h8000_0180;

  excp_ctrl dut (
    .clk                (clk),
    .rst                (rst),
    .stall_i            (stall_i),
    .mem_valid_i        (mem_valid_i),
    .mem_pc_i           (mem_pc_i),
    .mem_in_delayslot_i (mem_in_delayslot_i),
    .mem_syscall_i      (mem_syscall_i),
    .mem_invalid_i      (mem_invalid_i),
    .mem_ov_i           (mem_ov_i),
    .mem_eret_i         (mem_eret_i),
    .mem_cp0_we_i       (mem_cp0_we_i),
    .mem_cp0_waddr_i    (mem_cp0_waddr_i),
    .mem_cp0_wdata_i    (mem_cp0_wdata_i),
    .cp0_status_i       (cp0_status_i),
    .cp0_cause_i        (cp0_cause_i),
    .cp0_epc_i          (cp0_epc_i),
    .exception_type_o   (exception_type_o),
    .pc_o               (pc_o),
    .is_in_delayslot_o  (is_in_delayslot_o),
    .flush_o            (flush_o),
    .new_pc_o           (new_pc_o),
    .busy_o             (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  task automatic clear_flags();
    mem_syscall_i = 1'b0;
    mem_invalid_i = 1'b0;
    mem_ov_i      = 1'b0;
    mem_eret_i    = 1'b0;
    mem_cp0_we_i  = 1'b0;
  endtask

  initial begin
    rst                = 1'b1;
    stall_i            = 1'b0;
    mem_valid_i        = 1'b0;
    mem_pc_i           = 32'd0;
    mem_in_delayslot_i = 1'b0;
    clear_flags();
    mem_cp0_waddr_i    = 5'd0;
    mem_cp0_wdata_i    = 32'd0;
    cp0_status_i       = 32'd0;
    cp0_cause_i        = 32'd0;
    cp0_epc_i          = 32'd0;
    tick();
    tick();

    // Reset: outputs forced to zero even with a syscall presented.
    mem_valid_i   = 1'b1;
    mem_pc_i      = 32'h0000_1000;
    mem_syscall_i = 1'b1;
    settle();
    check("rst_type",  exception_type_o, 32'd0);
    check("rst_flush", {31'd0, flush_o}, 32'd0);
    check("rst_pc",    pc_o, 32'd0);
    check("rst_newpc", new_pc_o, 32'd0);
    check("rst_busy",  {31'd0, busy_o}, 32'd0);

    // 1. Syscall at 0x1000.
    rst = 1'b0;
    settle();
    check("sys_type",  exception_type_o, 32'd8);
    check("sys_pc",    pc_o, 32'h0000_1000);
    check("sys_ds",    {31'd0, is_in_delayslot_o}, 32'd0);
    check("sys_flush", {31'd0, flush_o}, 32'd1);
    check("sys_newpc", new_pc_o, HANDLER);
    check("sys_busy0", {31'd0, busy_o}, 32'd0);
    tick();
    clear_flags();
    settle();
    check("sys_blank1", {31'd0, busy_o}, 32'd1);
    check("sys_noflush", {31'd0, flush_o}, 32'd0);
    tick();
    check("sys_blank2", {31'd0, busy_o}, 32'd1);
    tick();
    check("sys_blank3", {31'd0, busy_o}, 32'd1);
    tick();
    check("sys_idle", {31'd0, busy_o}, 32'd0);

    // 2. invalid + ov + syscall -> invalid_inst; flags ignored during BLANK.
    mem_pc_i           = 32'h0000_1004;
    mem_in_delayslot_i = 1'b1;
    mem_invalid_i      = 1'b1;
    mem_ov_i           = 1'b1;
    mem_syscall_i      = 1'b1;
    settle();
    check("multi_type", exception_type_o, 32'd10);
    check("multi_ds",   {31'd0, is_in_delayslot_o}, 32'd1);
    check("multi_flush", {31'd0, flush_o}, 32'd1);
    tick();
    check("blank_flush1", {31'd0, flush_o}, 32'd0);
    check("blank_type1",  exception_type_o, 32'd0);
    check("blank_newpc1", new_pc_o, 32'd0);
    check("blank_pcpass", pc_o, 32'h0000_1004);
    tick();
    check("blank_flush2", {31'd0, flush_o}, 32'd0);
    tick();
    check("blank_flush3", {31'd0, flush_o}, 32'd0);
    check("blank_busy3",  {31'd0, busy_o}, 32'd1);
    tick();
    // Back in IDLE with flags still up: accepted in the very next cycle.
    check("reaccept_busy",  {31'd0, busy_o}, 32'd0);
    check("reaccept_flush", {31'd0, flush_o}, 32'd1);
    check("reaccept_type",  exception_type_o, 32'd10);
    clear_flags();
    mem_in_delayslot_i = 1'b0;
    settle();
    check("idle_noflush", {31'd0, flush_o}, 32'd0);
    tick();
    check("idle_stay", {31'd0, busy_o}, 32'd0);

    // Stall in IDLE blocks acceptance.
    stall_i       = 1'b1;
    mem_syscall_i = 1'b1;
    settle();
    check("stall_noflush", {31'd0, flush_o}, 32'd0);
    tick();
    check("stall_nobusy", {31'd0, busy_o}, 32'd0);
    stall_i = 1'b0;
    clear_flags();

    // 3. Interrupt, suppressed by a forwarded Status write of 0.
    mem_pc_i        = 32'h0000_3000;
    cp0_status_i    = 32'h0000_FF01;
    cp0_cause_i     = 32'h0000_0400;
    mem_cp0_we_i    = 1'b1;
    mem_cp0_waddr_i = 5'd12;
    mem_cp0_wdata_i = 32'd0;
    settle();
    check("int_fwd_type",  exception_type_o, 32'd0);
    check("int_fwd_flush", {31'd0, flush_o}, 32'd0);
    mem_cp0_we_i = 1'b0;
    cp0_status_i = 32'h0000_FF03;
    settle();
    check("int_exl_type", exception_type_o, 32'd0);
    cp0_status_i = 32'h0000_FF01;
    mem_ov_i     = 1'b1;
    settle();
    check("int_type",  exception_type_o, 32'd1);
    check("int_flush", {31'd0, flush_o}, 32'd1);
    check("int_newpc", new_pc_o, HANDLER);
    tick();
    clear_flags();
    cp0_status_i = 32'd0;
    cp0_cause_i  = 32'd0;
    tick();
    tick();
    tick();
    check("int_drained", {31'd0, busy_o}, 32'd0);

    // 4. ERET: plain EPC, then with a forwarded EPC write.
    cp0_epc_i  = 32'h0000_5000;
    mem_eret_i = 1'b1;
    settle();
    check("eret_epc", new_pc_o, 32'h0000_5000);
    mem_cp0_we_i    = 1'b1;
    mem_cp0_waddr_i = 5'd14;
    mem_cp0_wdata_i = 32'h0000_2040;
    settle();
    check("eret_type",  exception_type_o, 32'd14);
    check("eret_fwd",   new_pc_o, 32'h0000_2040);
    check("eret_flush", {31'd0, flush_o}, 32'd1);
    tick();
    clear_flags();
    tick();
    tick();
    tick();
    check("eret_drained", {31'd0, busy_o}, 32'd0);

    // 5. Interrupt pending through two bubbles; taken on first valid cycle.
    // The pending bit comes from a forwarded Cause[9:8] write (sw int 0).
    cp0_status_i    = 32'h0000_0101;
    mem_cp0_we_i    = 1'b1;
    mem_cp0_waddr_i = 5'd13;
    mem_cp0_wdata_i = 32'h0000_0100;
    mem_valid_i     = 1'b0;
    mem_pc_i        = 32'h0000_4000;
    settle();
    check("bub1_flush", {31'd0, flush_o}, 32'd0);
    check("bub1_pc",    pc_o, 32'h0000_4000);
    tick();
    check("bub2_flush", {31'd0, flush_o}, 32'd0);
    check("bub2_busy",  {31'd0, busy_o}, 32'd0);
    tick();
    mem_valid_i = 1'b1;
    mem_pc_i    = 32'h0000_4004;
    settle();
    check("defer_type", exception_type_o, 32'd1);
    check("defer_pc",   pc_o, 32'h0000_4004);
    check("defer_flush", {31'd0, flush_o}, 32'd1);
    tick();
    clear_flags();
    cp0_status_i = 32'd0;
    check("defer_busy", {31'd0, busy_o}, 32'd1);

    // 6. Stall for 4 cycles mid-BLANK: 3 + 4 busy cycles in total.
    stall_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("stall_busy%0d", i), {31'd0, busy_o}, 32'd1);
    end
    stall_i = 1'b0;
    tick();
    check("post_stall1", {31'd0, busy_o}, 32'd1);
    tick();
    check("post_stall2", {31'd0, busy_o}, 32'd1);
    tick();
    check("post_stall_idle", {31'd0, busy_o}, 32'd0);

    // Reset mid-BLANK.
    mem_syscall_i = 1'b1;
    tick();
    check("rb_busy", {31'd0, busy_o}, 32'd1);
    rst = 1'b1;
    settle();
    check("rb_type",  exception_type_o, 32'd0);
    check("rb_flush", {31'd0, flush_o}, 32'd0);
    tick();
    check("rb_idle", {31'd0, busy_o}, 32'd0);
    rst = 1'b0;
    clear_flags();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
